// File: rtl/gc_popcount_accum_if.sv
// Handshake bundle for gc_popcount_accum: event-vector intake (valid/ready) and count report (valid/yumi).
// Define GC_ACCUM_OVF_EN to carry the sticky saturation flag ovf_o.
interface gc_popcount_accum_if #(
  parameter int width_p     = 8,
  parameter int cnt_width_p = 16
);
  logic                   v_i;
  logic [width_p-1:0]     data_i;
  logic                   ready_o;
  logic                   flush_i;
  logic                   v_o;
  logic [cnt_width_p-1:0] count_o;
  logic                   yumi_i;
`ifdef GC_ACCUM_OVF_EN
  logic                   ovf_o;

  modport slave (
    input  v_i, data_i, flush_i, yumi_i,
    output ready_o, v_o, count_o, ovf_o
  );

  modport master (
    output v_i, data_i, flush_i, yumi_i,
    input  ready_o, v_o, count_o, ovf_o
  );
`else
  modport slave (
    input  v_i, data_i, flush_i, yumi_i,
    output ready_o, v_o, count_o
  );

  modport master (
    output v_i, data_i, flush_i, yumi_i,
    input  ready_o, v_o, count_o
  );
`endif
endinterface

// File: rtl/gc_popcount_accum.sv
// Popcount feeder: registers each vector's population count, accumulates it into a saturating window
// and reports on threshold or flush. Optional GC_ACCUM_OVF_EN adds the sticky saturation flag ovf_o.
module gc_popcount_accum #(
  parameter int width_p     = 8,
  parameter int cnt_width_p = 16,
  parameter int threshold_p = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  gc_popcount_accum_if.slave  bus
);

  localparam int pc_width_lp = $clog2(width_p + 1);
  localparam logic [cnt_width_p-1:0] threshold_lp = cnt_width_p'(threshold_p);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic                   pc_v_reg, pc_v_next;
  logic [cnt_width_p-1:0] pc_reg, pc_next;
  logic [cnt_width_p-1:0] acc_reg, acc_next;
  logic                   flush_pend_reg, flush_pend_next;
`ifdef GC_ACCUM_OVF_EN
  logic                   ovf_reg, ovf_next;
`endif

  logic [pc_width_lp-1:0] bit_ext [width_p];
  logic [pc_width_lp-1:0] popcnt;
  logic [cnt_width_p:0]   sum;
  logic [cnt_width_p-1:0] sum_sat;
  logic                   ready;
  logic                   accept;

  genvar gi;
  generate
    for (gi = 0; gi < width_p; gi++) begin : g_bit_ext
      assign bit_ext[gi] = pc_width_lp'(bus.data_i[gi]);
    end
  endgenerate

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < width_p; i++) begin
      popcnt = popcnt + bit_ext[i];
    end
  end

  // One extra bit catches the carry so the window clamps instead of wrapping.
  assign sum     = {1'b0, acc_reg} + {1'b0, (pc_v_reg ? pc_reg : '0)};
  assign sum_sat = sum[cnt_width_p] ? '1 : sum[cnt_width_p-1:0];

  assign ready  = (state_reg == ACCUM) | ~pc_v_reg;
  assign accept = bus.v_i & ready;

  assign bus.ready_o = ready;
  assign bus.v_o     = (state_reg == REPORT);
  assign bus.count_o = acc_reg;
`ifdef GC_ACCUM_OVF_EN
  assign bus.ovf_o   = ovf_reg;
`endif

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    flush_pend_next = flush_pend_reg;
    pc_next         = pc_reg;
    pc_v_next       = pc_v_reg;
`ifdef GC_ACCUM_OVF_EN
    ovf_next        = ovf_reg;
`endif

    unique case (state_reg)
      ACCUM: begin
        acc_next = sum_sat;
`ifdef GC_ACCUM_OVF_EN
        ovf_next = ovf_reg | sum[cnt_width_p];
`endif
        // A flush reports even an empty window so downstream sees a barrier.
        if ((sum_sat >= threshold_lp) || flush_pend_reg || bus.flush_i) begin
          state_next      = REPORT;
          flush_pend_next = 1'b0;
        end
      end
      REPORT: begin
        if (bus.flush_i) begin
          flush_pend_next = 1'b1;
        end
        if (bus.yumi_i) begin
          acc_next   = '0;
          state_next = ACCUM;
`ifdef GC_ACCUM_OVF_EN
          ovf_next   = 1'b0;
`endif
        end
      end
      default: state_next = ACCUM;
    endcase

    // The accumulator drains stage 1 every ACCUM cycle; a new accept overrides the drain.
    if (accept) begin
      pc_next   = cnt_width_p'(popcnt);
      pc_v_next = 1'b1;
    end else if (state_reg == ACCUM) begin
      pc_v_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ACCUM;
      pc_v_reg       <= 1'b0;
      pc_reg         <= '0;
      acc_reg        <= '0;
      flush_pend_reg <= 1'b0;
`ifdef GC_ACCUM_OVF_EN
      ovf_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      pc_v_reg       <= pc_v_next;
      pc_reg         <= pc_next;
      acc_reg        <= acc_next;
      flush_pend_reg <= flush_pend_next;
`ifdef GC_ACCUM_OVF_EN
      ovf_reg        <= ovf_next;
`endif
    end
  end

endmodule

// File: tb/tb_gc_popcount_accum.sv
// Bench for gc_popcount_accum: a default instance and a narrow saturating instance, each checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_gc_popcount_accum;

  logic clk;
  logic rst_n;

  gc_popcount_accum_if #(.width_p(8), .cnt_width_p(16)) bus0 ();
  gc_popcount_accum_if #(.width_p(8), .cnt_width_p(4))  bus1 ();

  gc_popcount_accum #(.width_p(8), .cnt_width_p(16), .threshold_p(64)) dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0)
  );

  gc_popcount_accum #(.width_p(8), .cnt_width_p(4), .threshold_p(15)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Model state per instance: window, held popcount, report pending, queued flush, overflow.
  int m_acc [2] = '{0, 0};
  int m_pc  [2] = '{0, 0};
  bit m_pcv [2] = '{0, 0};
  bit m_rep [2] = '{0, 0};
  bit m_fp  [2] = '{0, 0};
  bit m_ovf [2] = '{0, 0};
  int n_acc     = 0;

  // Literal expectation request (-1 = don't care), consumed by the compare process.
  bit lit_on   = 0;
  int lit_k    = 0;
  int lit_v    = -1;
  int lit_cnt  = -1;
  int lit_rdy  = -1;
  int lit_ovf  = -1;
  int lit_nacc = -1;
  int nacc_base = 0;

  task automatic mstep(input int k, input logic v, input logic [7:0] d, input logic fl,
                       input logic y, input int mx, input int th);
    bit was_rep = m_rep[k];
    bit rdy     = !m_rep[k] || !m_pcv[k];
    int s;
    if (!was_rep) begin
      s = m_acc[k] + (m_pcv[k] ? m_pc[k] : 0);
      if (s > mx) begin
        s = mx;
        m_ovf[k] = 1;
      end
      m_acc[k] = s;
      if (s >= th || m_fp[k] || fl) begin
        m_rep[k] = 1;
        m_fp[k]  = 0;
      end
    end else begin
      if (fl) m_fp[k] = 1;
      if (y) begin
        m_acc[k] = 0;
        m_rep[k] = 0;
        m_ovf[k] = 0;
      end
    end
    if (v && rdy) begin
      m_pc[k]  = $countones(d);
      m_pcv[k] = 1;
    end else if (!was_rep) begin
      m_pcv[k] = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_acc[k] = 0; m_pc[k] = 0; m_pcv[k] = 0;
          m_rep[k] = 0; m_fp[k] = 0; m_ovf[k] = 0;
        end
      end else begin
        if (bus0.v_o && bus0.yumi_i) $display("dut0 report taken count=%0d", bus0.count_o);
        if (bus1.v_o && bus1.yumi_i) $display("dut1 report taken count=%0d", bus1.count_o);
        if (bus0.v_i && bus0.ready_o) n_acc++;
        mstep(0, bus0.v_i, bus0.data_i, bus0.flush_i, bus0.yumi_i, 65535, 64);
        mstep(1, bus1.v_i, bus1.data_i, bus1.flush_i, bus1.yumi_i, 15, 15);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    longint av, ac, ar, ao;
    forever begin
      @(negedge clk);
      chk("dut0_v",     bus0.v_o,     m_rep[0]);
      chk("dut0_count", bus0.count_o, m_acc[0]);
      chk("dut0_ready", bus0.ready_o, (!m_rep[0] || !m_pcv[0]));
      chk("dut1_v",     bus1.v_o,     m_rep[1]);
      chk("dut1_count", bus1.count_o, m_acc[1]);
      chk("dut1_ready", bus1.ready_o, (!m_rep[1] || !m_pcv[1]));
      chk("dut0_yumi_legal", (bus0.yumi_i && !bus0.v_o), 0);
      chk("dut1_yumi_legal", (bus1.yumi_i && !bus1.v_o), 0);
`ifdef GC_ACCUM_OVF_EN
      chk("dut0_ovf", bus0.ovf_o, m_ovf[0]);
      chk("dut1_ovf", bus1.ovf_o, m_ovf[1]);
`endif
      if (lit_on) begin
        ao = 0;
        if (lit_k == 0) begin
          av = bus0.v_o; ac = bus0.count_o; ar = bus0.ready_o;
`ifdef GC_ACCUM_OVF_EN
          ao = bus0.ovf_o;
`endif
        end else begin
          av = bus1.v_o; ac = bus1.count_o; ar = bus1.ready_o;
`ifdef GC_ACCUM_OVF_EN
          ao = bus1.ovf_o;
`endif
        end
        if (lit_v >= 0)    chk("lit_v",     av, lit_v);
        if (lit_cnt >= 0)  chk("lit_count", ac, lit_cnt);
        if (lit_rdy >= 0)  chk("lit_ready", ar, lit_rdy);
        if (lit_nacc >= 0) chk("lit_accepts", n_acc - nacc_base, lit_nacc);
`ifdef GC_ACCUM_OVF_EN
        if (lit_ovf >= 0)  chk("lit_ovf",   ao, lit_ovf);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit_chk(input int k, input int v, input int c, input int r, input int o, input int na);
    lit_k = k; lit_v = v; lit_cnt = c; lit_rdy = r; lit_ovf = o; lit_nacc = na;
    lit_on = 1;
    @(negedge clk);
    #1;
    lit_on = 0;
  endtask

  task automatic feed0(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus0.v_i = 1; bus0.data_i = d;
      tick();
    end
    bus0.v_i = 0;
  endtask

  // Flush and retire whatever dut0 holds, bounded so a stuck design cannot hang the run.
  task automatic drain0();
    int n = 0;
    bus0.flush_i = 1;
    tick();
    bus0.flush_i = 0;
    while (!bus0.v_o && n < 20) begin
      tick();
      n++;
    end
    lit_chk(0, 1, -1, -1, -1, -1);
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;
  endtask

  initial begin
    rst_n = 0;
    bus0.v_i = 0; bus0.data_i = '0; bus0.flush_i = 0; bus0.yumi_i = 0;
    bus1.v_i = 0; bus1.data_i = '0; bus1.flush_i = 0; bus1.yumi_i = 0;

    // Reset state
    lit_chk(0, 0, 0, 1, 0, -1);
    lit_chk(1, 0, 0, 1, 0, -1);
    tick();
    rst_n = 1;
    tick();

    // Eight full vectors reach 64 and report two cycles after the last accept
    feed0(8'hFF, 8);
    lit_chk(0, 0, 56, 1, -1, -1);
    tick();
    lit_chk(0, 1, 64, 1, 0, -1);
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;
    lit_chk(0, 0, 0, 1, -1, -1);

    // Single item then flush; then an empty flush still reports 0
    feed0(8'h01, 1);
    bus0.flush_i = 1;
    tick();
    bus0.flush_i = 0;
    lit_chk(0, 1, 1, 1, -1, -1);
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;
    bus0.flush_i = 1;
    tick();
    bus0.flush_i = 0;
    lit_chk(0, 1, 0, 1, -1, -1);
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;

    // Backpressure during REPORT with a flush queued behind it
    nacc_base = n_acc;
    for (int i = 0; i < 8; i++) begin
      bus0.v_i = 1; bus0.data_i = 8'hFF;
      tick();
    end
    bus0.data_i = 8'h0F;
    tick();
    lit_chk(0, 1, 64, 0, -1, 9);
    for (int i = 0; i < 5; i++) begin
      bus0.flush_i = (i == 0);
      tick();
      lit_chk(0, 1, 64, 0, -1, 9);
    end
    bus0.flush_i = 0;
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;
    lit_chk(0, 0, 0, 1, -1, 9);
    tick();
    lit_chk(0, 1, 4, 0, -1, 10);
    bus0.v_i = 0;
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;
    tick();
    lit_chk(0, 0, 4, 1, -1, -1);
    drain0();
    lit_chk(0, 0, 0, 1, -1, -1);

    // Saturation on the narrow instance: 7 + 7 + 8 clamps at 15
    bus1.v_i = 1; bus1.data_i = 8'h7F; tick();
    tick();
    bus1.data_i = 8'hFF; tick();
    bus1.v_i = 0;
    lit_chk(1, 0, 14, 1, 0, -1);
    tick();
    lit_chk(1, 1, 15, 1, 1, -1);
    bus1.yumi_i = 1;
    tick();
    bus1.yumi_i = 0;
    lit_chk(1, 0, 0, 1, 0, -1);

    // Async reset during REPORT with a held item and a pending flush
    feed0(8'hFF, 8);
    tick();
    bus0.v_i = 1; bus0.data_i = 8'h0F; bus0.flush_i = 1;
    tick();
    bus0.v_i = 0; bus0.flush_i = 0;
    #1;
    rst_n = 0;
    lit_chk(0, 0, 0, 1, 0, -1);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit_chk(0, 0, 0, 1, -1, -1);
    end
    feed0(8'hFF, 8);
    tick();
    lit_chk(0, 1, 64, 1, -1, -1);
    bus0.yumi_i = 1;
    tick();
    bus0.yumi_i = 0;
    lit_chk(0, 0, 0, 1, -1, -1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gc_popcount_accum.md
Name: gc_popcount_accum

Overview:
- Upstream feeder for the popcount datapath: accepts event bit-vectors (e.g. per-cycle commit/check valid masks) on a valid/ready handshake.
- Registers each vector's population count, then accumulates the counts into a windowed counter.
- Emits a count report on a valid/yumi handshake when the threshold is reached or on flush.
- Consumed by the checker-side credit and statistics logic.

Parameters:
- width_p, 8, input vector width; popcount width is $clog2(width_p+1).
- cnt_width_p, 16, accumulator/report width; must be >= $clog2(width_p+1).
- threshold_p, 64, report trigger level; legal range 1..2^cnt_width_p-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- v_i  in  1  data_i valid.
- data_i  in  width_p  event vector.
- ready_o  out  1  stage can accept data_i.
- flush_i  in  1  single-cycle request to report the current count early.
- v_o  out  1  report valid.
- count_o  out  cnt_width_p  report value; held stable while v_o=1.
- yumi_i  in  1  consumer takes report; legal only while v_o=1.

Behaviour:
- Reset (async assert, sync release) clears everything: state=ACCUM, pc_v_r=0, pc_r=0, acc_r=0, flush_pend_r=0.
- Outputs after reset: v_o=0, count_o=0, ready_o=1.
- Stage 1:
  - ready_o = (state==ACCUM) | ~pc_v_r.
  - On v_i&ready_o: pc_r <= popcount(data_i), zero-extended to cnt_width_p; pc_v_r <= 1.
  - Otherwise, if the accumulator consumed pc_r this cycle: pc_v_r <= 0.
  - Accept and consume in the same cycle: new value loads and pc_v_r stays 1.
- ACCUM state:
  - acc_nxt = sat(acc_r + (pc_v_r ? pc_r : 0)); saturates at 2^cnt_width_p-1, never wraps.
  - pc_r is always consumed when pc_v_r=1.
  - Each cycle: acc_r <= acc_nxt.
  - Go to REPORT if acc_nxt >= threshold_p, or flush_pend_r, or flush_i. The same-cycle pc_r is included in the report.
  - A flush with acc_nxt=0 still reports count 0 (barrier semantics).
  - Leaving for REPORT clears flush_pend_r.
- REPORT state:
  - v_o=1 and count_o=acc_r; acc_r and pc_r are frozen.
  - Stage 1 may hold at most one item; ready_o falls once pc_v_r=1.
  - On yumi_i: acc_r <= 0, state <= ACCUM.
  - The held pc_r folds into the new window on the first ACCUM cycle.
- count_o = acc_r in all states; v_o=0 in ACCUM.
- flush_i in REPORT sets flush_pend_r, so another report (possibly 0) follows immediately after return to ACCUM. Multiple flushes merge into one.
- Latency: item accepted in cycle N is folded at the end of N+1; a triggered v_o is high from N+2.
- yumi_i while v_o=0 is ignored; a bench assertion flags it.
- Reset mid-operation: held item, partial window and pending flush are all discarded; no report is emitted.

Optional Feature:
- Macro GC_ACCUM_OVF_EN.
- Defined:
  - Adds port ovf_o (out, 1).
  - Sticky ovf_r sets when any ACCUM addition saturates.
  - ovf_o = ovf_r, valid alongside v_o; cleared with acc_r on yumi_i and by reset.
- Undefined: no port, no register; saturation is silent. All other behaviour is identical.

Test Plan:
- Defaults; reset; eight back-to-back data_i=8'hFF -> v_o high 2 cycles after the 8th accept with count_o=64; yumi_i -> next cycle v_o=0, count_o=0.
- Accept data_i=8'h01, pulse flush_i the following cycle -> v_o with count_o=1. Then flush_i with no data -> second report with count_o=0.
- Eight 8'hFF followed by continuous 8'h0F, yumi_i low for 5 cycles -> count_o stable at 64, exactly one extra item accepted, ready_o=0 while held. After yumi_i, acc=4 on the first ACCUM cycle and intake resumes.
- flush_i pulsed during REPORT -> after yumi_i a second report fires immediately with count_o equal to what was folded that cycle (4 in the previous setup).
- cnt_width_p=4, threshold_p=15: feed 8'h7F, 8'h7F (acc 14), then 8'hFF -> count_o=15 (saturated, not 22 mod 16). With GC_ACCUM_OVF_EN, ovf_o=1; it clears after yumi_i.
- Drop rst_ni asynchronously mid-cycle during REPORT -> v_o=0, count_o=0, ready_o=1 without a clock edge. After release, no stale report appears and a fresh 8x8'hFF run reports 64.
